// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Instruction-fetch sequencer between a combinational instruction ROM and
//   the decode stage. Owns the fetch PC, reads one word per cycle, and
//   buffers {pc, instr} pairs in a DEPTH-entry prefetch FIFO that decode
//   drains with a valid/ready handshake. A redirect flushes the FIFO and
//   restarts fetch at the new PC.
//
//   Optional feature macro: FETCH_FAULT_EN
//     defined   : alignment/bounds check on the fetch PC; the first bad PC
//                 sets a sticky fault and halts fetch until redirect/reset.
//     undefined : no checks, fetch PC wraps mod MEM_BYTES, fault outputs 0.
//
// Ports
//   clk_i          clock, all state on posedge
//   reset_i        synchronous active-high reset
//   imem_addr_o    ROM byte address (the fetch PC register)
//   imem_instr_i   ROM read data for imem_addr_o, same cycle
//   redirect_i     redirect request (one-cycle pulse)
//   redirect_pc_i  new fetch PC, sampled with redirect_i
//   out_valid_o    FIFO head valid
//   out_instr_o    head instruction (0 when empty)
//   out_pc_o       head PC (0 when empty)
//   out_ready_i    decode accepts the head this cycle
//   fault_o        sticky fetch fault
//   fault_pc_o     PC that caused the fault (0 when no fault)

module imem_fetch_ctrl #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [63:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        out_valid_o,
  output logic [31:0] out_instr_o,
  output logic [63:0] out_pc_o,
  input  logic        out_ready_i,
  output logic        fault_o,
  output logic [63:0] fault_pc_o
);

  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [63:0] MEM_BYTES_64 = 64'(MEM_BYTES);

  logic [63:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic [63:0]      fetch_pc_q;
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fault_q;
  logic [63:0]      fault_pc_q;

  logic             fetch_ok;
  logic [63:0]      fetch_pc_inc;
  logic             push, pop;

`ifdef FETCH_FAULT_EN
  // 65-bit sum so a PC near the top of the address space cannot wrap
  // around and pass the bounds check.
  assign fetch_ok     = (fetch_pc_q[1:0] == 2'b00) &&
                        (({1'b0, fetch_pc_q} + 65'd3) < {1'b0, MEM_BYTES_64});
  assign fetch_pc_inc = fetch_pc_q + 64'd4;
`else
  // No checking: fault_q is never set, so fault outputs stay 0.
  assign fetch_ok     = 1'b1;
  assign fetch_pc_inc = (fetch_pc_q + 64'd4) & (MEM_BYTES_64 - 64'd1);
`endif

  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o & out_ready_i & ~redirect_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push        = ~redirect_i & ~fault_q & fetch_ok &
                       ((count_q < CNT_W'(DEPTH)) | pop);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: contents are only visible while count_q != 0.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_q]    <= fetch_pc_q;
      instr_mem[wr_q] <= imem_instr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q <= RESET_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else if (redirect_i) begin
      fetch_pc_q <= redirect_pc_i;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      if (push) begin
        wr_q       <= wr_q + PTR_W'(1);
        fetch_pc_q <= fetch_pc_inc;
      end
      if (pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      count_q <= count_d;
      if (~fault_q & ~fetch_ok) begin
        fault_q    <= 1'b1;
        fault_pc_q <= fetch_pc_q;
      end
    end
  end

  assign imem_addr_o = fetch_pc_q;
  assign out_instr_o = out_valid_o ? instr_mem[rd_q] : 32'h0;
  assign out_pc_o    = out_valid_o ? pc_mem[rd_q]    : 64'h0;
  assign fault_o     = fault_q;
  assign fault_pc_o  = fault_q ? fault_pc_q : 64'h0;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl. A queue-based reference model
// tracks the fetch PC, prefetch contents and fault state cycle by cycle.
module tb_imem_fetch_ctrl;

  localparam int              DEPTH = 4;
  localparam longint unsigned MEMB  = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;
  logic        fault;
  logic [63:0] fault_pc;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.DEPTH(DEPTH), .MEM_BYTES(1024), .RESET_PC(64'h0)) dut (
    .clk_i(clk), .reset_i(reset), .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .out_valid_o(out_valid),
    .out_instr_o(out_instr), .out_pc_o(out_pc), .out_ready_i(out_ready),
    .fault_o(fault), .fault_pc_o(fault_pc)
  );

  // ROM contents: odd multiplier makes every word distinct.
  function automatic logic [31:0] rom(input logic [63:0] a);
    return a[31:0] * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  always_comb imem_instr = rom(imem_addr);

  typedef struct packed { logic [63:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_q[$];
  logic [63:0] m_pc;
  bit          m_fault;
  logic [63:0] m_fpc;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic bit m_ok(input logic [63:0] pc);
`ifdef FETCH_FAULT_EN
    return (pc % 4 == 0) && (pc < MEMB - 3);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step(input bit rst, input bit red, input logic [63:0] rpc, input bit rdy);
    bit do_pop, do_push, ok;
    if (rst) begin
      m_q.delete(); m_pc = 64'h0; m_fault = 0; m_fpc = 64'h0;
    end else if (red) begin
      m_q.delete(); m_pc = rpc; m_fault = 0; m_fpc = 64'h0;
    end else begin
      ok      = m_ok(m_pc);
      do_pop  = (m_q.size() != 0) && rdy;
      do_push = !m_fault && ok && ((m_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back('{pc: m_pc, instr: rom(m_pc)});
`ifdef FETCH_FAULT_EN
        m_pc = m_pc + 64'd4;
`else
        m_pc = (m_pc + 64'd4) % MEMB;
`endif
      end else if (!m_fault && !ok) begin
        m_fault = 1; m_fpc = m_pc;
      end
    end
  endtask

  task automatic step(input bit rst, input bit red, input logic [63:0] rpc, input bit rdy);
    reset = rst; redirect = red; redirect_pc = rpc; out_ready = rdy;
    model_step(rst, red, rpc, rdy);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [225:0] exp_vec();
    ent_t h;
    h = (m_q.size() != 0) ? m_q[0] : '0;
    return {m_q.size() != 0, h.pc, h.instr, m_pc, m_fault, m_fault ? m_fpc : 64'h0};
  endfunction

  function automatic logic [225:0] obs_vec();
    return {out_valid, out_pc, out_instr, imem_addr, fault, fault_pc};
  endfunction

  task automatic test_reset();
    step(1, 0, 64'h0, 0);
    step(1, 0, 64'h0, 0);
    n_tests++;
    if (obs_vec() !== {1'b0, 64'h0, 32'h0, 64'h0, 1'b0, 64'h0}) begin
      n_fail++; $display("FAIL reset_values got %h exp all-zero", obs_vec());
    end
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 64'h0, 1);
      n_tests++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 64'(4 * i), rom(64'(4 * i))}) begin
        n_fail++;
        $display("FAIL stream cyc %0d got v=%0b pc=%h ins=%h exp pc=%h", i, out_valid, out_pc, out_instr, 4 * i);
      end
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stream_model cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    step(1, 0, 64'h0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 64'h0, 0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL bp_hold cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (imem_addr !== 64'h10 || out_pc !== 64'h0) begin
      n_fail++; $display("FAIL bp_full got addr=%h pc=%h exp addr=10 pc=0", imem_addr, out_pc);
    end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * k)) begin
        n_fail++; $display("FAIL bp_release k=%0d got v=%0b pc=%h exp pc=%h", k, out_valid, out_pc, 4 * k);
      end
      step(0, 0, 64'h0, 1);
    end
  endtask

  task automatic test_full_pushpop();
    step(1, 0, 64'h0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 64'h0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 64'h0, 1);
      n_tests++;
      // Count stays at DEPTH: fetch PC stays four words ahead of the head.
      if (out_pc !== 64'(4 * (i + 1)) || imem_addr !== 64'(4 * (i + 1) + 16)) begin
        n_fail++; $display("FAIL full_pushpop cyc %0d got pc=%h addr=%h exp pc=%h", i, out_pc, imem_addr, 4 * (i + 1));
      end
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL full_model cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_redirect();
    step(1, 0, 64'h0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 64'h0, 0);
    step(0, 1, 64'h40, 1);
    n_tests++;
    if (out_valid !== 1'b0 || imem_addr !== 64'h40) begin
      n_fail++; $display("FAIL redirect_flush got v=%0b addr=%h exp v=0 addr=40", out_valid, imem_addr);
    end
    step(0, 0, 64'h0, 1);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_instr !== rom(64'h40)) begin
      n_fail++; $display("FAIL redirect_target got v=%0b pc=%h exp pc=40", out_valid, out_pc);
    end
    step(0, 0, 64'h0, 1);
    n_tests++;
    if (out_pc !== 64'h44) begin
      n_fail++; $display("FAIL redirect_next got pc=%h exp 44", out_pc);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 1, 64'h100, 1);
    step(0, 1, 64'h200, 1);
    n_tests++;
    if (out_valid !== 1'b0 || imem_addr !== 64'h200) begin
      n_fail++; $display("FAIL b2b_addr got v=%0b addr=%h exp v=0 addr=200", out_valid, imem_addr);
    end
    step(0, 0, 64'h0, 1);
    n_tests++;
    if (out_pc !== 64'h200 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL b2b_target got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

`ifdef FETCH_FAULT_EN
  task automatic test_fault();
    step(0, 1, 64'h3FC, 1);
    step(0, 0, 64'h0, 1);
    n_tests++;
    if (out_pc !== 64'h3FC || fault !== 1'b0) begin
      n_fail++; $display("FAIL fault_last_word got pc=%h fault=%0b exp pc=3fc fault=0", out_pc, fault);
    end
    step(0, 0, 64'h0, 1);
    step(0, 0, 64'h0, 1);
    n_tests++;
    if (fault !== 1'b1 || fault_pc !== 64'h400 || out_valid !== 1'b0 || imem_addr !== 64'h400) begin
      n_fail++; $display("FAIL fault_bounds got f=%0b fpc=%h v=%0b addr=%h exp 1/400/0/400", fault, fault_pc, out_valid, imem_addr);
    end
    step(0, 1, 64'h0, 1);
    step(0, 0, 64'h0, 1);
    n_tests++;
    if (fault !== 1'b0 || fault_pc !== 64'h0 || out_pc !== 64'h0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL fault_clear got f=%0b fpc=%h pc=%h v=%0b", fault, fault_pc, out_pc, out_valid);
    end
    step(0, 1, 64'h6, 1);
    step(0, 0, 64'h0, 1);
    n_tests++;
    if (fault !== 1'b1 || fault_pc !== 64'h6 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL fault_misalign got f=%0b fpc=%h v=%0b exp 1/6/0", fault, fault_pc, out_valid);
    end
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL fault_model got %h exp %h", obs_vec(), exp_vec());
    end
  endtask
`else
  task automatic test_wrap();
    step(0, 1, 64'h3FC, 1);
    step(0, 0, 64'h0, 1);
    n_tests++;
    if (out_pc !== 64'h3FC || imem_addr !== 64'h0) begin
      n_fail++; $display("FAIL wrap_last got pc=%h addr=%h exp pc=3fc addr=0", out_pc, imem_addr);
    end
    step(0, 0, 64'h0, 1);
    n_tests++;
    if (out_pc !== 64'h0 || out_instr !== rom(64'h0) || fault !== 1'b0 || fault_pc !== 64'h0) begin
      n_fail++; $display("FAIL wrap_zero got pc=%h ins=%h f=%0b exp pc=0", out_pc, out_instr, fault);
    end
  endtask
`endif

  task automatic test_reset_midstream();
    for (int i = 0; i < 6; i++) step(0, 0, 64'h0, 0);
    step(1, 1, 64'h80, 1);
    n_tests++;
    if (obs_vec() !== {1'b0, 64'h0, 32'h0, 64'h0, 1'b0, 64'h0}) begin
      n_fail++; $display("FAIL reset_midstream got %h exp all-zero", obs_vec());
    end
    step(0, 0, 64'h0, 1);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0) begin
      n_fail++; $display("FAIL reset_restart got v=%0b pc=%h exp v=1 pc=0", out_valid, out_pc);
    end
  endtask

  task automatic test_random();
    logic [63:0] rpc;
    bit          rst, red, rdy;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      red = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = 64'($urandom_range(0, 1030));
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step(rst, red, rpc, rdy);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pushpop();
    test_redirect();
    test_back_to_back();
`ifdef FETCH_FAULT_EN
    test_fault();
`else
    test_wrap();
`endif
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer sitting between the combinational instruction ROM and the decode stage of the pipelined CPU. Owns the fetch PC, reads one 32-bit word per cycle from the ROM, and buffers fetched words with their PCs in a small prefetch FIFO that decode drains with a valid/ready handshake. Handles branch redirects by flushing the FIFO and restarting fetch, and optionally flags fetches outside the ROM.

## Interface
- DEPTH, 4: prefetch FIFO entries; power of two, ≥2.
- MEM_BYTES, 1024: ROM size in bytes; power of two, >4; must match the ROM's configured size.
- RESET_PC, 64'h0: fetch PC loaded on reset; word-aligned.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  64  byte address to ROM; equals fetch_pc register, no combinational path from inputs.
- imem_instr  in  32  ROM read data for imem_addr, same cycle.
- redirect  in  1  branch taken/redirect request, one-cycle pulse.
- redirect_pc  in  64  new fetch PC, sampled when redirect=1.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_instr  out  32  head instruction; 0 when empty.
- out_pc  out  64  head PC; 0 when empty.
- out_ready  in  1  decode accepts head this cycle.
- fault  out  1  sticky fetch fault (only with FETCH_FAULT_EN; tied 0 otherwise).
- fault_pc  out  64  PC that caused fault; 0 when fault=0.

## Operation
- State: fetch_pc (64 b), FIFO of DEPTH entries {pc[63:0], instr[31:0]}, rd/wr pointers (log2 DEPTH b, wrap mod DEPTH), count (log2 DEPTH + 1 b, 0..DEPTH), fault/fault_pc.
- pop = out_valid & out_ready & ~redirect.
- push = ~redirect & ~fault & fetch_ok & (count < DEPTH | pop). Pushes {fetch_pc, imem_instr}; fetch_pc <= fetch_pc + 4.
- fetch_ok = 1 without FETCH_FAULT_EN; with it, fetch_pc[1:0]==0 and fetch_pc+3 < MEM_BYTES (64-bit compare, no truncation).
- Full and pop same cycle: push and pop both occur, count unchanged.
- Empty: out_valid=0; no same-cycle bypass of imem_instr to outputs (fill latency is one cycle).
- Redirect (highest priority after reset): FIFO flushed (count=0, pointers to 0), fetch_pc <= redirect_pc, fault and fault_pc cleared, no push, no pop (head shown that cycle is discarded, not consumed). Back-to-back redirects: last one wins.
- Fault (FETCH_FAULT_EN): when ~redirect & ~fault & ~fetch_ok, set fault=1, fault_pc <= fetch_pc; fetch stops, fetch_pc holds; FIFO still drains normally. Cleared only by redirect or reset.
- Without FETCH_FAULT_EN: fetch_pc increments as (fetch_pc+4) mod MEM_BYTES after reaching the end; redirect_pc low bits above log2 MEM_BYTES and [1:0] passed unchanged to imem_addr.

## Timing
- Reset values: fetch_pc=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0, imem_addr=RESET_PC.
- First edge after reset deasserts: word at RESET_PC pushed; out_valid=1 the following cycle.
- Redirect at edge N: imem_addr=redirect_pc after N; target instruction at out_valid after N+1 (one-cycle redirect bubble).
- Steady-state throughput: one instruction per cycle with out_ready held 1.
- Reset mid-operation (including during fault or with full FIFO): all state returns to reset values at that edge; reset overrides redirect.
- out_* driven from registers/FIFO storage only; out_ready affects state, not same-cycle outputs.

## Configuration
- FETCH_FAULT_EN defined: alignment and bounds checking, fault/fault_pc live, fetch halts on first bad PC.
- Not defined: no checks, fetch_pc wraps mod MEM_BYTES, fault and fault_pc constant 0; all other behaviour identical.

## Test plan
- Reset, out_ready=1 with ROM words 0..7 = distinct patterns -> out_valid rises cycle 1, out_pc sequence 0,4,8,... one per cycle, out_instr matches ROM.
- out_ready=0 for 10 cycles -> FIFO fills to 4 entries (PCs 0..12), imem_addr holds 16; release -> PCs 0,4,8,12,16 delivered in order, no gap, no duplicate.
- FIFO full, out_ready=1 -> simultaneous push/pop, count stays 4, stream unbroken.
- redirect=1, redirect_pc=0x40 while FIFO holds 3 entries -> next cycle out_valid=0, imem_addr=0x40; cycle after, out_pc=0x40; old entries never accepted.
- FETCH_FAULT_EN, redirect_pc=0x3FC -> word at 0x3FC delivered, then fault=1, fault_pc=0x400, no further pushes; redirect to 0x0 clears fault and resumes. Misaligned redirect_pc=0x6 -> fault=1, fault_pc=0x6 next cycle, out_valid stays 0.
- Without macro, redirect_pc=0x3FC -> out_pc 0x3FC then 0x0; reset asserted mid-stream with full FIFO -> all outputs at reset values next cycle.
